// File: rtl/bram_rd_arbiter_if.sv
// Client request/response and BRAM read-port signals of the shared line-buffer read controller.
// The slave modport is the arbiter's view; the master modport is the clients plus the BRAM.
interface bram_rd_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    logic              i_trig0;
    logic [ADDR_W-1:0] i_addr0;
    logic [DATA_W-1:0] o_data0;
    logic              o_done0;

    logic              i_trig1;
    logic [ADDR_W-1:0] i_addr1;
    logic [DATA_W-1:0] o_data1;
    logic              o_done1;

    logic              o_bram_en;
    logic [ADDR_W-1:0] o_bram_addr;
    logic [DATA_W-1:0] i_bram_dout;

    modport slave (
        input  i_trig0, i_addr0, i_trig1, i_addr1, i_bram_dout,
        output o_data0, o_done0, o_data1, o_done1, o_bram_en, o_bram_addr
    );

    modport master (
        output i_trig0, i_addr0, i_trig1, i_addr1, i_bram_dout,
        input  o_data0, o_done0, o_data1, o_done1, o_bram_en, o_bram_addr
    );
endinterface

// File: rtl/bram_rd_arbiter.sv
// Two-client round-robin read controller for the line-buffer BRAM: one access in flight,
// waits out RD_LAT, then returns the dword with a one-cycle done pulse to the granted client.
module bram_rd_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    bram_rd_arbiter_if.slave     bus
);
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CAPTURE
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              last_q;
    logic              armed0_q;
    logic              armed1_q;
    logic              en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data0_q;
    logic [DATA_W-1:0] data1_q;
    logic              done0_q;
    logic              done1_q;

    logic              elig0_d;
    logic              elig1_d;
    logic              sel_d;

    // A client only competes once its trig has been seen low since its last grant.
    always_comb begin
        elig0_d = bus.i_trig0 & armed0_q;
        elig1_d = bus.i_trig1 & armed1_q;
        sel_d   = (elig0_d & elig1_d) ? ~last_q : elig1_d;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            armed0_q <= 1'b1;
            armed1_q <= 1'b1;
            en_q     <= 1'b0;
            addr_q   <= '0;
            data0_q  <= '0;
            data1_q  <= '0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
        end else begin
            en_q    <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            if (!bus.i_trig0) armed0_q <= 1'b1;
            if (!bus.i_trig1) armed1_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (elig0_d | elig1_d) begin
                        en_q    <= 1'b1;
                        addr_q  <= sel_d ? bus.i_addr1 : bus.i_addr0;
                        cnt_q   <= CNT_LOAD;
                        last_q  <= sel_d;
                        if (sel_d) armed1_q <= 1'b0;
                        else       armed0_q <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // Leaving on the count of one lands the capture RD_LAT edges after the BRAM sample.
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_q <= CAPTURE;
                end
                CAPTURE: begin
                    if (last_q) begin
                        data1_q <= bus.i_bram_dout;
                        done1_q <= 1'b1;
                    end else begin
                        data0_q <= bus.i_bram_dout;
                        done0_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_bram_en   = en_q;
    assign bus.o_bram_addr = addr_q;
    assign bus.o_data0     = data0_q;
    assign bus.o_done0     = done0_q;
    assign bus.o_data1     = data1_q;
    assign bus.o_done1     = done1_q;

endmodule

// File: doc/bram_rd_arbiter.md
# bram_rd_arbiter

Shared read controller for the connected-domain filter line buffer. It sits directly below the row readers: each reader raises a trig/addr request for one 32-bit dword, and this block grants requests round-robin between two clients and drives the single BRAM read port. It waits out the BRAM read latency, then returns the dword with a one-cycle done pulse. It hides BRAM latency and port sharing from the row-level state machines.

## Interface
- ADDR_W, 13: BRAM dword address width ({row[8:0], dword[3:0]}).
- DATA_W, 32: BRAM data width.
- RD_LAT, 2: BRAM read latency in clocks, counted from the edge that samples en/addr to the edge where dout is valid. Legal range 1–4.

- i_clk  in  1  clock.
- i_rstn  in  1  reset; asynchronous, active-low.
- i_trig0  in  1  client 0 request; held high until done is seen.
- i_addr0  in  ADDR_W  client 0 dword address; valid whenever i_trig0 is high.
- o_data0  out  DATA_W  client 0 read data; registered, held until the next client 0 completion.
- o_done0  out  1  client 0 completion; one-cycle pulse.
- i_trig1, i_addr1, o_data1, o_done1: same as above, for client 1.
- o_bram_en  out  1  BRAM read enable; one-cycle pulse per access.
- o_bram_addr  out  ADDR_W  BRAM read address; registered.
- i_bram_dout  in  DATA_W  BRAM read data.

## Operation
- State machine: IDLE, WAIT, CAPTURE.
- **IDLE**
  - Eligible client: trig high and its armed flag set.
  - If any client is eligible, grant it. Latch its addr into o_bram_addr, pulse o_bram_en, load the latency counter with RD_LAT, record the grant in the last-grant pointer, clear the client's armed flag, and go to WAIT.
- **WAIT**
  - Decrement the counter each cycle. At zero, go to CAPTURE.
- **CAPTURE**
  - Write i_bram_dout into the granted client's o_data and pulse its o_done for one cycle. Return to IDLE.
- **Arbitration**
  - If both clients are eligible in the same cycle, grant the client not granted last.
  - After reset, the pointer favours client 0.
  - Only one access is outstanding at a time.
- **Re-arm rule**
  - A client's armed flag sets on any cycle its trig is sampled low.
  - This blocks double-service of a request whose trig is still high in the cycle after done.
- **Address latching**
  - The address is latched at grant. Later changes to i_addrN during that access are ignored.
- **Abandoned request**
  - A client that drops trig mid-access still receives its done pulse and data update; then the normal re-arm applies.
- **Idle outputs**
  - The data output of a non-granted client never changes.
  - o_bram_addr holds its last value when idle.
- **Reset** (asynchronous, any state)
  - State → IDLE.
  - All outputs → 0, including o_data0, o_data1 and o_bram_addr.
  - Both armed flags → 1; pointer → "last = client 1".
  - A trig already high at reset release is treated as a fresh request.

## Timing
- Grant edge Eg: trig sampled high → o_bram_en=1 and o_bram_addr valid during cycle Eg..Eg+1.
- The BRAM samples at Eg+1. o_data and o_done are updated at edge Eg+RD_LAT+1.
- Request-to-done latency: RD_LAT+1 clocks (3 at default).
- o_done is high for exactly one cycle. At Ed+1 it is 0, even if trig is still high.
- A client that drops trig at Ed+1 and re-raises it at Ed+2 with a new addr is granted at Ed+3. Per-client dword period is RD_LAT+4 clocks (6 at default).
- The other client can be granted at Ed+1; there is no dead cycle between clients.
- o_bram_en never rises on two consecutive edges.

## Test plan
- **Single read.** RD_LAT=2, BRAM[0x0015]=0xDEADBEEF, client 0 raises trig with addr 0x0015.
  - o_bram_en pulses once with addr 0x0015.
  - o_data0=0xDEADBEEF and o_done0=1 exactly 3 clocks after trig is sampled; o_done0=0 the following cycle.
  - o_data1 stays 0.
- **Row burst.** Client 0 reads dwords {row 5, 0..15} in row-reader style: drop trig one cycle after done, re-raise with the next addr.
  - 16 grants, addr 0x0050..0x005F in order, each done 6 clocks apart.
  - Each o_data0 equals BRAM content; no address is repeated.
- **Contention.** Both trig rise in the same cycle after reset, addr0=0x0100, addr1=0x0200.
  - Client 0 is served first, client 1 next, with o_bram_en at Eg and Eg+4.
  - Sustained contention alternates 0,1,0,1.
- **Stale trig.** Client holds trig high for 5 cycles after done without changing addr.
  - No second o_bram_en and no second done until trig is seen low.
- **Address change mid-access.** i_addr1 changes from 0x0033 to 0x0044 during WAIT.
  - Returned data is from 0x0033.
- **Reset mid-access.** Assert i_rstn=0 in WAIT, release with trig0 still high.
  - All outputs 0 during reset.
  - After release a new grant starts and completes normally with a single done.
